// File: rtl/jtag_tap_top.sv
// IEEE 1149.1 TAP controller with 5-bit instruction decode, internal IDCODE/BYPASS
// registers and a gated clock/data path that streams the bitstream to the PMU.
module jtag_tap_top #(
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
  parameter int unsigned IR_W         = 5
) (
  input  logic tck_i,
  input  logic rst_ni,
  input  logic tms_i,
  input  logic td_i,
  output logic td_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_dr_o,
  output logic memory_sel_o,
  output logic fifo_sel_o,
  output logic confreg_sel_o,
  output logic clk_byp_sel_o,
  output logic observ_sel_o,
  output logic pmu_w_cs_sel_o,
  output logic pmu_wo_cs_sel_o,
  output logic checksum_en,
  output logic pmu_en,
  output logic scan_in_o,
  output logic pmu_tdi_o,
  output logic pmu_tck_o,
  output logic pmu_rst_o,
  input  logic memory_out_i,
  input  logic fifo_out_i,
  input  logic confreg_out_i,
  input  logic clk_byp_out_i,
  input  logic observ_out_i,
  input  logic pmu_tdo_i
);

  localparam logic [IR_W-1:0] OP_IDCODE      = IR_W'(5'b00010);
  localparam logic [IR_W-1:0] OP_REG1        = IR_W'(5'b00100);
  localparam logic [IR_W-1:0] OP_REG2        = IR_W'(5'b00101);
  localparam logic [IR_W-1:0] OP_REG3        = IR_W'(5'b00110);
  localparam logic [IR_W-1:0] OP_REG_CLK_BYP = IR_W'(5'b00111);
  localparam logic [IR_W-1:0] OP_REG_OBSERV  = IR_W'(5'b01000);
  localparam logic [IR_W-1:0] OP_PMU_WO_CS   = IR_W'(5'b11010);
  localparam logic [IR_W-1:0] OP_PMU_W_CS    = IR_W'(5'b11011);
  localparam logic [IR_W-1:0] IR_CAPTURE     = IR_W'(5'b00001);

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAU_DR, ST_EX2_DR,
    ST_UPD_DR, ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAU_IR, ST_EX2_IR, ST_UPD_IR
  } tap_state_e;

  tap_state_e        r_state;
  tap_state_e        w_state_nxt;
  logic [IR_W-1:0]   r_ir_sr;
  logic [IR_W-1:0]   r_ir;
  logic [31:0]       r_idcode_sr;
  logic              r_bypass;
  logic              r_tdo;
  logic              r_pmu_clk_en;

  logic w_idc_sel, w_byp_sel, w_mem_sel, w_fifo_sel, w_conf_sel, w_clkb_sel, w_obs_sel;
  logic w_pmu_w_sel, w_pmu_wo_sel, w_dr_tdo, w_pmu_en;

  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_TLR;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_TLR:    w_state_nxt = tms_i ? ST_TLR    : ST_RTI;
      ST_RTI:    w_state_nxt = tms_i ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: w_state_nxt = tms_i ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: w_state_nxt = tms_i ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  w_state_nxt = tms_i ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: w_state_nxt = tms_i ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: w_state_nxt = tms_i ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: w_state_nxt = tms_i ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: w_state_nxt = tms_i ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: w_state_nxt = tms_i ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: w_state_nxt = tms_i ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  w_state_nxt = tms_i ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: w_state_nxt = tms_i ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: w_state_nxt = tms_i ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: w_state_nxt = tms_i ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: w_state_nxt = tms_i ? ST_SEL_DR : ST_RTI;
      default:   w_state_nxt = ST_TLR;
    endcase
  end

  // Instruction shift register and the latched instruction it feeds.
  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ir_sr <= IR_CAPTURE;
      r_ir    <= OP_IDCODE;
    end else begin
      if (r_state == ST_CAP_IR)     r_ir_sr <= IR_CAPTURE;
      else if (r_state == ST_SH_IR) r_ir_sr <= {td_i, r_ir_sr[IR_W-1:1]};
      if (r_state == ST_TLR)        r_ir    <= OP_IDCODE;
      else if (r_state == ST_UPD_IR) r_ir   <= r_ir_sr;
    end
  end

  // Unlisted opcodes (REG6 included) fall through to BYPASS.
  always_comb begin
    w_idc_sel    = 1'b0;
    w_byp_sel    = 1'b0;
    w_mem_sel    = 1'b0;
    w_fifo_sel   = 1'b0;
    w_conf_sel   = 1'b0;
    w_clkb_sel   = 1'b0;
    w_obs_sel    = 1'b0;
    w_pmu_w_sel  = 1'b0;
    w_pmu_wo_sel = 1'b0;
    w_dr_tdo     = r_bypass;
    case (r_ir)
      OP_IDCODE:      begin w_idc_sel    = 1'b1; w_dr_tdo = r_idcode_sr[0]; end
      OP_REG1:        begin w_mem_sel    = 1'b1; w_dr_tdo = memory_out_i;   end
      OP_REG2:        begin w_fifo_sel   = 1'b1; w_dr_tdo = fifo_out_i;     end
      OP_REG3:        begin w_conf_sel   = 1'b1; w_dr_tdo = confreg_out_i;  end
      OP_REG_CLK_BYP: begin w_clkb_sel   = 1'b1; w_dr_tdo = clk_byp_out_i;  end
      OP_REG_OBSERV:  begin w_obs_sel    = 1'b1; w_dr_tdo = observ_out_i;   end
      OP_PMU_W_CS:    begin w_pmu_w_sel  = 1'b1; w_dr_tdo = pmu_tdo_i;      end
      OP_PMU_WO_CS:   begin w_pmu_wo_sel = 1'b1; w_dr_tdo = pmu_tdo_i;      end
      default:        w_byp_sel = 1'b1;
    endcase
  end

  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idcode_sr <= IDCODE_VALUE;
      r_bypass    <= 1'b0;
    end else begin
      if (w_idc_sel && r_state == ST_CAP_DR)     r_idcode_sr <= IDCODE_VALUE;
      else if (w_idc_sel && r_state == ST_SH_DR) r_idcode_sr <= {td_i, r_idcode_sr[31:1]};
      if (w_byp_sel && r_state == ST_CAP_DR)     r_bypass <= 1'b0;
      else if (w_byp_sel && r_state == ST_SH_DR) r_bypass <= td_i;
    end
  end

  always_ff @(negedge tck_i or negedge rst_ni) begin
    if (!rst_ni)                r_tdo <= 1'b0;
    else if (r_state == ST_SH_IR) r_tdo <= r_ir_sr[0];
    else if (r_state == ST_SH_DR) r_tdo <= w_dr_tdo;
    else                        r_tdo <= 1'b0;
  end

  // Clock-gate enable only changes while tck is low, so pmu_tck_o never glitches.
  assign w_pmu_en = (w_pmu_w_sel || w_pmu_wo_sel) && (r_state == ST_RTI);

  always_latch begin
    if (!rst_ni)     r_pmu_clk_en <= 1'b0;
    else if (!tck_i) r_pmu_clk_en <= w_pmu_en;
  end

  assign td_o            = r_tdo;
  assign shift_dr_o      = (r_state == ST_SH_DR);
  assign update_dr_o     = (r_state == ST_UPD_DR);
  assign capture_dr_o    = (r_state == ST_CAP_DR);
  assign memory_sel_o    = w_mem_sel;
  assign fifo_sel_o      = w_fifo_sel;
  assign confreg_sel_o   = w_conf_sel;
  assign clk_byp_sel_o   = w_clkb_sel;
  assign observ_sel_o    = w_obs_sel;
  assign pmu_w_cs_sel_o  = w_pmu_w_sel;
  assign pmu_wo_cs_sel_o = w_pmu_wo_sel;
  assign checksum_en     = w_pmu_w_sel;
  assign pmu_en          = w_pmu_en;
  assign scan_in_o       = td_i;
  assign pmu_tdi_o       = w_pmu_en & td_i;
  assign pmu_tck_o       = tck_i & r_pmu_clk_en;
  assign pmu_rst_o       = rst_ni & (r_state != ST_TLR);

endmodule

// File: tb/tb_jtag_tap_top.sv
// Directed bench for jtag_tap_top: reset, IDCODE, BYPASS, DR selects and PMU streaming.
module tb_jtag_tap_top;
  localparam logic [31:0] IDC = 32'h1000_0001;

  logic tck_i = 1'b0;
  logic rst_ni = 1'b1;
  logic tms_i = 1'b1;
  logic td_i = 1'b0;
  logic memory_out_i = 1'b0, fifo_out_i = 1'b0, confreg_out_i = 1'b0;
  logic clk_byp_out_i = 1'b0, observ_out_i = 1'b0, pmu_tdo_i = 1'b0;
  logic td_o, shift_dr_o, update_dr_o, capture_dr_o;
  logic memory_sel_o, fifo_sel_o, confreg_sel_o, clk_byp_sel_o, observ_sel_o;
  logic pmu_w_cs_sel_o, pmu_wo_cs_sel_o, checksum_en, pmu_en;
  logic scan_in_o, pmu_tdi_o, pmu_tck_o, pmu_rst_o;
  logic [6:0] sels;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  jtag_tap_top #(.IDCODE_VALUE(IDC), .IR_W(5)) dut (
    .tck_i(tck_i), .rst_ni(rst_ni), .tms_i(tms_i), .td_i(td_i), .td_o(td_o),
    .shift_dr_o(shift_dr_o), .update_dr_o(update_dr_o), .capture_dr_o(capture_dr_o),
    .memory_sel_o(memory_sel_o), .fifo_sel_o(fifo_sel_o), .confreg_sel_o(confreg_sel_o),
    .clk_byp_sel_o(clk_byp_sel_o), .observ_sel_o(observ_sel_o),
    .pmu_w_cs_sel_o(pmu_w_cs_sel_o), .pmu_wo_cs_sel_o(pmu_wo_cs_sel_o),
    .checksum_en(checksum_en), .pmu_en(pmu_en), .scan_in_o(scan_in_o),
    .pmu_tdi_o(pmu_tdi_o), .pmu_tck_o(pmu_tck_o), .pmu_rst_o(pmu_rst_o),
    .memory_out_i(memory_out_i), .fifo_out_i(fifo_out_i), .confreg_out_i(confreg_out_i),
    .clk_byp_out_i(clk_byp_out_i), .observ_out_i(observ_out_i), .pmu_tdo_i(pmu_tdo_i)
  );

  assign sels = {memory_sel_o, fifo_sel_o, confreg_sel_o, clk_byp_sel_o, observ_sel_o,
                 pmu_w_cs_sel_o, pmu_wo_cs_sel_o};

  initial forever #5 tck_i = ~tck_i;

  always @(posedge pmu_tck_o) pulse_cnt++;

  // One TCK cycle; returns 1 time unit after the falling edge.
  task automatic clk(input logic t, input logic d);
    tms_i = t;
    td_i  = d;
    @(posedge tck_i);
    @(negedge tck_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tms_i  = 1'b1;
    td_i   = 1'b0;
    @(negedge tck_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic set_dr(input logic [5:0] v);
    {memory_out_i, fifo_out_i, confreg_out_i, clk_byp_out_i, observ_out_i, pmu_tdo_i} = v;
  endtask

  // From Run-Test/Idle, shift in an opcode LSB-first; ends in Update-IR.
  task automatic load_ir(input logic [4:0] code);
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    n_vec++;
    if (td_o !== 1'b1) begin
      n_err++;
      $display("FAIL ir_capture_tdo: got %b want 1", td_o);
    end
    for (int i = 0; i < 5; i++) clk(i == 4, code[i]);
    clk(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #3;
    n_vec++;
    if ({td_o, shift_dr_o, update_dr_o, capture_dr_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_dr_flags: got %b want 0000", {td_o, shift_dr_o, update_dr_o, capture_dr_o});
    end
    n_vec++;
    if (sels !== 7'b0) begin
      n_err++;
      $display("FAIL reset_sels: got %b want 0000000", sels);
    end
    n_vec++;
    if ({pmu_en, pmu_rst_o, checksum_en, pmu_tck_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_pmu: got %b want 0000", {pmu_en, pmu_rst_o, checksum_en, pmu_tck_o});
    end
    @(negedge tck_i);
    #1 rst_ni = 1'b1;
    n_vec++;
    if (pmu_rst_o !== 1'b0) begin
      n_err++;
      $display("FAIL tlr_pmu_rst: got %b want 0", pmu_rst_o);
    end
    clk(1'b0, 1'b0);
    n_vec++;
    if (pmu_rst_o !== 1'b1) begin
      n_err++;
      $display("FAIL rti_pmu_rst: got %b want 1", pmu_rst_o);
    end
  endtask

  task automatic test_idcode();
    logic [31:0] idc;
    idc = IDC;
    do_reset();
    clk(1'b0, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    n_vec++;
    if (capture_dr_o !== 1'b1) begin
      n_err++;
      $display("FAIL capture_dr: got %b want 1", capture_dr_o);
    end
    clk(1'b0, 1'b0);
    n_vec++;
    if (shift_dr_o !== 1'b1) begin
      n_err++;
      $display("FAIL shift_dr: got %b want 1", shift_dr_o);
    end
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (td_o !== idc[i]) begin
        n_err++;
        $display("FAIL idcode_bit%0d: got %b want %b", i, td_o, idc[i]);
      end
      clk(i == 31, 1'b0);
    end
    clk(1'b1, 1'b0);
    n_vec++;
    if (update_dr_o !== 1'b1) begin
      n_err++;
      $display("FAIL update_dr: got %b want 1", update_dr_o);
    end
    clk(1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    logic [4:0] codes [3];
    logic [3:0] pat;
    codes[0] = 5'b11111;
    codes[1] = 5'b01001;
    codes[2] = 5'b10101;
    pat = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      load_ir(codes[c]);
      clk(1'b0, 1'b0);
      n_vec++;
      if (sels !== 7'b0) begin
        n_err++;
        $display("FAIL bypass_sels_%b: got %b want 0000000", codes[c], sels);
      end
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      clk(1'b0, 1'b0);
      n_vec++;
      if (td_o !== 1'b0) begin
        n_err++;
        $display("FAIL bypass_capture_%b: got %b want 0", codes[c], td_o);
      end
      for (int i = 0; i < 4; i++) begin
        clk(1'b0, pat[i]);
        n_vec++;
        if (td_o !== pat[i]) begin
          n_err++;
          $display("FAIL bypass_shift_%b_bit%0d: got %b want %b", codes[c], i, td_o, pat[i]);
        end
      end
      clk(1'b1, 1'b0);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
    end
  endtask

  task automatic test_sel_regs();
    logic [4:0] codes [7];
    logic [6:0] want;
    logic [5:0] src;
    codes[0] = 5'b00100; codes[1] = 5'b00101; codes[2] = 5'b00110; codes[3] = 5'b00111;
    codes[4] = 5'b01000; codes[5] = 5'b11011; codes[6] = 5'b11010;
    for (int c = 0; c < 7; c++) begin
      want = 7'b1000000 >> c;
      src  = (c < 5) ? (6'b100000 >> c) : 6'b000001;
      load_ir(codes[c]);
      clk(1'b0, 1'b0);
      n_vec++;
      if (sels !== want) begin
        n_err++;
        $display("FAIL sel_%b: got %b want %b", codes[c], sels, want);
      end
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
      clk(1'b0, 1'b0);
      set_dr(src);
      clk(1'b0, 1'b0);
      n_vec++;
      if (td_o !== 1'b1) begin
        n_err++;
        $display("FAIL dr_out_hi_%b: got %b want 1", codes[c], td_o);
      end
      set_dr(~src);
      clk(1'b0, 1'b0);
      n_vec++;
      if (td_o !== 1'b0) begin
        n_err++;
        $display("FAIL dr_out_lo_%b: got %b want 0", codes[c], td_o);
      end
      set_dr(6'b0);
      clk(1'b1, 1'b0);
      clk(1'b1, 1'b0);
      clk(1'b0, 1'b0);
    end
  endtask

  task automatic test_pmu(input logic [4:0] code, input int ncyc, input logic cs);
    int start;
    do_reset();
    clk(1'b0, 1'b0);
    load_ir(code);
    start = pulse_cnt;
    for (int i = 0; i < ncyc; i++) clk(1'b0, 1'b1);
    n_vec++;
    if ({pmu_en, pmu_tdi_o, checksum_en} !== {2'b11, cs}) begin
      n_err++;
      $display("FAIL pmu_stream_%b: got en/tdi/cs %b want %b", code, {pmu_en, pmu_tdi_o, checksum_en}, {2'b11, cs});
    end
    n_vec++;
    if (sels !== (cs ? 7'b0000010 : 7'b0000001)) begin
      n_err++;
      $display("FAIL pmu_sel_%b: got %b want %b", code, sels, cs ? 7'b0000010 : 7'b0000001);
    end
    td_i = 1'b0;
    #1;
    n_vec++;
    if (pmu_tdi_o !== 1'b0) begin
      n_err++;
      $display("FAIL pmu_tdi_follow_%b: got %b want 0", code, pmu_tdi_o);
    end
    for (int i = 0; i < 5; i++) clk(1'b1, 1'b0);
    n_vec++;
    if (pulse_cnt - start !== ncyc) begin
      n_err++;
      $display("FAIL pmu_pulses_%b: got %0d want %0d", code, pulse_cnt - start, ncyc);
    end
    n_vec++;
    if ({pmu_en, pmu_rst_o} !== 2'b00) begin
      n_err++;
      $display("FAIL pmu_tlr_%b: got en/rst %b want 00", code, {pmu_en, pmu_rst_o});
    end
  endtask

  task automatic test_reset_mid();
    int start;
    do_reset();
    clk(1'b0, 1'b0);
    load_ir(5'b00100);
    clk(1'b0, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    memory_out_i = 1'b1;
    clk(1'b0, 1'b0);
    n_vec++;
    if ({td_o, shift_dr_o} !== 2'b11) begin
      n_err++;
      $display("FAIL mid_pre_reset: got %b want 11", {td_o, shift_dr_o});
    end
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({td_o, shift_dr_o, update_dr_o, capture_dr_o, sels} !== 11'b0) begin
      n_err++;
      $display("FAIL mid_reset_dr: got %b want 0", {td_o, shift_dr_o, update_dr_o, capture_dr_o, sels});
    end
    n_vec++;
    if ({pmu_en, pmu_rst_o, checksum_en} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_reset_pmu: got %b want 000", {pmu_en, pmu_rst_o, checksum_en});
    end
    memory_out_i = 1'b0;
    @(negedge tck_i);
    #1 rst_ni = 1'b1;
    clk(1'b0, 1'b0);
    load_ir(5'b11011);
    for (int i = 0; i < 4; i++) clk(1'b0, 1'b1);
    n_vec++;
    if (pmu_en !== 1'b1) begin
      n_err++;
      $display("FAIL mid_stream_en: got %b want 1", pmu_en);
    end
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({pmu_en, pmu_rst_o, checksum_en, pmu_w_cs_sel_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_stream_reset: got %b want 0000", {pmu_en, pmu_rst_o, checksum_en, pmu_w_cs_sel_o});
    end
    start = pulse_cnt;
    @(negedge tck_i);
    #1;
    n_vec++;
    if (pulse_cnt !== start) begin
      n_err++;
      $display("FAIL mid_stream_gated: got %0d pulses want 0", pulse_cnt - start);
    end
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_bypass();
    test_sel_regs();
    test_pmu(5'b11011, 64, 1'b1);
    test_pmu(5'b11010, 2500, 1'b0);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
